hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use, multi-cycle MUL/DIV and taken-branch hazards.
// Define HZD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int INDEX    = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             idex_mem_read_in,
  input  logic [INDEX-1:0] idex_rd_in,
  input  logic [INDEX-1:0] ifid_rs1_in,
  input  logic [INDEX-1:0] ifid_rs2_in,
  input  logic             ifid_rs1_used_in,
  input  logic             ifid_rs2_used_in,
  input  logic             mdu_start_in,
  input  logic             mdu_done_in,
  input  logic             branch_taken_in,
  output logic             stall_out,
  output logic             idex_bubble_out,
  output logic             idex_hold_out,
  output logic             exmem_bubble_out,
  output logic             ifid_flush_out
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cycles_out,
  output logic [PERF_W-1:0] flush_count_out
`endif
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_WAIT = 2'd1;
  localparam logic [1:0] S_MDU_WAIT  = 2'd2;
  localparam logic [3:0] LOAD_CNT    = 4'(LOAD_LAT - 1);

  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
    $error("hazard_ctrl: LOAD_LAT=%0d outside 1..15", LOAD_LAT);
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("hazard_ctrl: PERF_W=%0d must be at least 1", PERF_W);
  end

  logic [1:0] state_r, state_d;
  logic [3:0] cnt_r, cnt_d;
  logic       load_use;
  logic       stall_c, bubble_c, hold_c, exbub_c, flush_c;

  // x0 never carries a real dependency, and unused operand fields are don't-care.
  assign load_use = idex_mem_read_in && (idex_rd_in != '0) &&
                    ((ifid_rs1_used_in && (idex_rd_in == ifid_rs1_in)) ||
                     (ifid_rs2_used_in && (idex_rd_in == ifid_rs2_in)));

  always_comb begin
    state_d  = state_r;
    cnt_d    = cnt_r;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    hold_c   = 1'b0;
    exbub_c  = 1'b0;
    flush_c  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (branch_taken_in) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (mdu_start_in && !mdu_done_in) begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          exbub_c = 1'b1;
          state_d = S_MDU_WAIT;
        end else if (mdu_start_in) begin
          state_d = S_IDLE;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = S_LOAD_WAIT;
            cnt_d   = LOAD_CNT;
          end
        end
      end
      S_LOAD_WAIT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        cnt_d    = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) state_d = S_IDLE;
      end
      S_MDU_WAIT: begin
        if (mdu_done_in) begin
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          exbub_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_d;
      cnt_r   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after the edge.
  assign stall_out        = stall_c  & ~rst_in;
  assign idex_bubble_out  = bubble_c & ~rst_in;
  assign idex_hold_out    = hold_c   & ~rst_in;
  assign exmem_bubble_out = exbub_c  & ~rst_in;
  assign ifid_flush_out   = flush_c  & ~rst_in;

`ifdef HZD_PERF_CNT_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cycles_out <= '0;
      flush_count_out  <= '0;
    end else begin
      if (stall_out)      stall_cycles_out <= sat_inc(stall_cycles_out);
      if (ifid_flush_out) flush_count_out  <= sat_inc(flush_count_out);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LAT 1, 3, 4) on shared stimulus vs. a behavioural model.
module tb_hazard_ctrl;
  localparam int N  = 3;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       mem_rd = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       rs1_u = 1'b0, rs2_u = 1'b0, mstart = 1'b0, mdone = 1'b0, br = 1'b0;
  logic [N-1:0] stall, bub, hold, exb, flush;
`ifdef HZD_PERF_CNT_EN
  logic [PW-1:0] scnt [N];
  logic [PW-1:0] fcnt [N];
`endif

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    hazard_ctrl #(
      .INDEX(5), .LOAD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4)), .PERF_W(PW)
    ) dut (
      .clk_in(clk), .rst_in(rst),
      .idex_mem_read_in(mem_rd), .idex_rd_in(rd),
      .ifid_rs1_in(rs1), .ifid_rs2_in(rs2),
      .ifid_rs1_used_in(rs1_u), .ifid_rs2_used_in(rs2_u),
      .mdu_start_in(mstart), .mdu_done_in(mdone), .branch_taken_in(br),
      .stall_out(stall[g]), .idex_bubble_out(bub[g]), .idex_hold_out(hold[g]),
      .exmem_bubble_out(exb[g]), .ifid_flush_out(flush[g])
`ifdef HZD_PERF_CNT_EN
      , .stall_cycles_out(scnt[g]), .flush_count_out(fcnt[g])
`endif
    );
  end

  // Reference model: outstanding load-stall cycles and an "MDU op pending" flag per instance.
  int lat [N] = '{1, 3, 4};
  int load_rem [N];
  bit mdu_wait [N];
  int m_scnt [N];
  int m_fcnt [N];

  function automatic bit lu();
    return mem_rd && (rd != 0) && ((rs1_u && rd == rs1) || (rs2_u && rd == rs2));
  endfunction

  // Packed as {stall, idex_bubble, idex_hold, exmem_bubble, ifid_flush}
  function automatic logic [4:0] exp_out(int k);
    if (rst) return 5'b00000;
    if (load_rem[k] > 0) return 5'b11000;
    if (mdu_wait[k]) return mdone ? 5'b00000 : 5'b10110;
    if (br) return 5'b01001;
    if (mstart) return mdone ? 5'b00000 : 5'b10110;
    if (lu()) return 5'b11000;
    return 5'b00000;
  endfunction

  function automatic logic [4:0] act_out(int k);
    return {stall[k], bub[k], hold[k], exb[k], flush[k]};
  endfunction

  task automatic tick();
    logic [4:0] e;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      e = exp_out(k);
      if (rst) begin
        load_rem[k] = 0; mdu_wait[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
      end else begin
        if (e[4] && m_scnt[k] < 3) m_scnt[k]++;
        if (e[0] && m_fcnt[k] < 3) m_fcnt[k]++;
        if (load_rem[k] > 0) load_rem[k]--;
        else if (mdu_wait[k]) begin
          if (mdone) mdu_wait[k] = 0;
        end
        else if (br) begin end
        else if (mstart) mdu_wait[k] = !mdone;
        else if (lu()) load_rem[k] = lat[k] - 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    mem_rd = 0; rd = 0; rs1 = 0; rs2 = 0; rs1_u = 0; rs2_u = 0;
    mstart = 0; mdone = 0; br = 0;
  endtask

  task automatic test_reset();
    mem_rd = 1; rd = 5; rs1 = 5; rs1_u = 1; mstart = 1; br = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_out(k) !== 5'b00000) begin
          errors++;
          $display("FAIL reset_outputs inst=%0d got=%b expected=00000", k, act_out(k));
        end
`ifdef HZD_PERF_CNT_EN
        checks++;
        if (scnt[k] !== '0 || fcnt[k] !== '0) begin
          errors++;
          $display("FAIL reset_counters inst=%0d got=%0d/%0d expected=0/0", k, scnt[k], fcnt[k]);
        end
`endif
      end
      tick();
    end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_load_use();
    mem_rd = 1; rd = 5; rs1 = 5; rs1_u = 1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_out(k) !== 5'b11000) begin
        errors++;
        $display("FAIL load_detect inst=%0d got=%b expected=11000", k, act_out(k));
      end
    end
    tick();
    idle_inputs();
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_out(k) !== ((c < lat[k]) ? 5'b11000 : 5'b00000)) begin
          errors++;
          $display("FAIL load_len inst=%0d cyc=%0d got=%b expected_stall=%0d", k, c, act_out(k), c < lat[k]);
        end
      end
      tick();
    end
    // rd = x0, then rs1 matching but unused: neither may stall
    mem_rd = 1; rd = 0; rs1 = 0; rs1_u = 1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_out(k) !== 5'b00000) begin
        errors++;
        $display("FAIL load_x0 inst=%0d got=%b expected=00000", k, act_out(k));
      end
    end
    tick();
    rd = 5; rs1 = 5; rs1_u = 0; rs2 = 5; rs2_u = 0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_out(k) !== 5'b00000) begin
        errors++;
        $display("FAIL load_unused inst=%0d got=%b expected=00000", k, act_out(k));
      end
    end
    tick();
    rs2_u = 1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_out(k) !== 5'b11000) begin
        errors++;
        $display("FAIL load_rs2 inst=%0d got=%b expected=11000", k, act_out(k));
      end
    end
    tick();
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_mdu();
    mstart = 1; mdone = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) mdone = 1;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_out(k) !== ((c < 4) ? 5'b10110 : 5'b00000)) begin
          errors++;
          $display("FAIL mdu_wait inst=%0d cyc=%0d got=%b expected_stall=%0d", k, c, act_out(k), c < 4);
        end
      end
      tick();
    end
    mstart = 1; mdone = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_out(k) !== 5'b00000) begin
          errors++;
          $display("FAIL mdu_same_cycle inst=%0d cyc=%0d got=%b expected=00000", k, c, act_out(k));
        end
      end
      tick();
      mstart = 0; mdone = 0;
    end
  endtask

  task automatic test_branch();
    br = 1; mem_rd = 1; rd = 7; rs1 = 7; rs1_u = 1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_out(k) !== 5'b01001) begin
        errors++;
        $display("FAIL branch_prio inst=%0d got=%b expected=01001", k, act_out(k));
      end
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_out(k) !== 5'b00000) begin
          errors++;
          $display("FAIL branch_after inst=%0d cyc=%0d got=%b expected=00000", k, c, act_out(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    mem_rd = 1; rd = 9; rs1 = 9; rs1_u = 1;
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    checks++;
    if (act_out(2) !== 5'b11000) begin
      errors++;
      $display("FAIL rst_mid_pre got=%b expected=11000", act_out(2));
    end
    #1 rst = 1;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_out(k) !== 5'b00000) begin
        errors++;
        $display("FAIL rst_mid_abort inst=%0d got=%b expected=00000", k, act_out(k));
      end
    end
    tick();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_out(k) !== 5'b00000) begin
          errors++;
          $display("FAIL rst_mid_after inst=%0d cyc=%0d got=%b expected=00000", k, c, act_out(k));
        end
      end
      tick();
    end
  endtask

`ifdef HZD_PERF_CNT_EN
  task automatic test_perf();
    rst = 1; tick(); rst = 0;
    br = 1; tick(); tick(); br = 0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (fcnt[k] !== PW'(2)) begin
        errors++;
        $display("FAIL perf_flush inst=%0d got=%0d expected=2", k, fcnt[k]);
      end
    end
    mem_rd = 1; rd = 3; rs1 = 3; rs1_u = 1;
    repeat (5) tick();
    idle_inputs();
    repeat (5) tick();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (scnt[k] !== PW'(3)) begin
        errors++;
        $display("FAIL perf_stall_sat inst=%0d got=%0d expected=3", k, scnt[k]);
      end
    end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 49) == 0);
      mem_rd = $urandom_range(0, 1);
      rd     = 5'($urandom_range(0, 3));
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      rs1_u  = $urandom_range(0, 1);
      rs2_u  = $urandom_range(0, 1);
      mstart = ($urandom_range(0, 5) == 0);
      mdone  = ($urandom_range(0, 3) == 0);
      br     = ($urandom_range(0, 6) == 0);
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_out(k) !== exp_out(k)) begin
          errors++;
          $display("FAIL random inst=%0d cyc=%0d got=%b expected=%b", k, c, act_out(k), exp_out(k));
        end
`ifdef HZD_PERF_CNT_EN
        checks++;
        if (scnt[k] !== PW'(m_scnt[k]) || fcnt[k] !== PW'(m_fcnt[k])) begin
          errors++;
          $display("FAIL random_perf inst=%0d cyc=%0d got=%0d/%0d expected=%0d/%0d",
                   k, c, scnt[k], fcnt[k], m_scnt[k], m_fcnt[k]);
        end
`endif
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      load_rem[k] = 0; mdu_wait[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
    #1;
    test_reset();
    test_load_use();
    test_mdu();
    test_branch();
    test_reset_mid_stall();
`ifdef HZD_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
